// File: rtl/ls_control_unit.sv
// ---------------------------------------------------------------------------
// ls_control_unit
// Multi-cycle control unit for the load-store datapath. Accepts RISC-V
// instruction words over a valid/ready handshake, decodes LD and SD
// (funct3 = 011), and walks each one through IDLE -> DECODE -> EXEC while
// driving register selectors, the address offset and one-cycle write
// enables. Rejected encodings produce a one-cycle ILLEGAL pulse instead.
//
// Ports:
//   i_clk           clock, all state changes on the rising edge
//   i_rst_n         asynchronous active-low reset
//   i_instr_valid   instruction word on i_instr is valid
//   i_instr         32-bit RISC-V instruction word
//   o_instr_ready   unit can accept a word (high only in IDLE)
//   o_ra            Ra selector (store data source)
//   o_rb            Rb selector (base address register)
//   o_c             address offset added to Rb
//   o_rw            register-file write selector (load destination)
//   o_we_rf         register-file write enable (EXEC only)
//   o_we_mem        data-memory write enable (EXEC only)
//   o_done          one-cycle pulse, instruction retired
//   o_illegal       one-cycle pulse, instruction rejected
//   o_load_count    retired LD count (wraps)
//   o_store_count   retired SD count (wraps)
// ---------------------------------------------------------------------------
module ls_control_unit #(
    parameter int CNT_W = 16,
    parameter int OFF_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_instr_valid,
    input  logic [31:0]      i_instr,
    output logic             o_instr_ready,
    output logic [OFF_W-1:0] o_ra,
    output logic [OFF_W-1:0] o_rb,
    output logic [OFF_W-1:0] o_c,
    output logic [OFF_W-1:0] o_rw,
    output logic             o_we_rf,
    output logic             o_we_mem,
    output logic             o_done,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_load_count,
    output logic [CNT_W-1:0] o_store_count
);

    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [2:0] F3_DBL  = 3'b011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [OFF_W-1:0]   r_ra;
    logic [OFF_W-1:0]   r_rb;
    logic [OFF_W-1:0]   r_c;
    logic [OFF_W-1:0]   r_rw;
    logic               r_weRf;
    logic               r_weMem;
    logic               r_done;
    logic               r_illegal;
    logic               r_legal;
    logic               r_isLoad;
    logic [CNT_W-1:0]   r_loadCount;
    logic [CNT_W-1:0]   r_storeCount;

    logic               w_accept;
    logic               w_isStore;
    logic               w_legal;

    // The offset adder has no sign extension, so the upper immediate bits
    // [31:25] must be zero for both formats; that rejects negative offsets
    // and anything above 31.
    assign w_accept  = i_instr_valid && (r_state == IDLE);
    assign w_isStore = (i_instr[6:0] == OPC_SD);
    assign w_legal   = ((i_instr[6:0] == OPC_LD) || w_isStore) &&
                       (i_instr[14:12] == F3_DBL) &&
                       (i_instr[31:25] == 7'd0);

    // State register; reset returns straight to IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode. DECODE and EXEC each last exactly one cycle;
    // an illegal word returns from DECODE directly to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = DECODE;
            DECODE:  w_nextState = r_legal ? EXEC : IDLE;
            EXEC:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Field capture, write enables, pulses and retirement counters.
    // Fields are captured only at the accept edge and then held, so the
    // Rb+C address is stable through DECODE and EXEC. A load to x0 never
    // raises WE_RF but still retires and counts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ra         <= '0;
            r_rb         <= '0;
            r_c          <= '0;
            r_rw         <= '0;
            r_weRf       <= 1'b0;
            r_weMem      <= 1'b0;
            r_done       <= 1'b0;
            r_illegal    <= 1'b0;
            r_legal      <= 1'b0;
            r_isLoad     <= 1'b0;
            r_loadCount  <= '0;
            r_storeCount <= '0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_legal  <= w_legal;
                        r_isLoad <= !w_isStore;
                        r_rb     <= OFF_W'(i_instr[19:15]);
                        if (w_isStore) begin
                            r_ra <= OFF_W'(i_instr[24:20]);
                            r_c  <= OFF_W'(i_instr[11:7]);
                            r_rw <= '0;
                        end else begin
                            r_ra <= '0;
                            r_c  <= OFF_W'(i_instr[24:20]);
                            r_rw <= OFF_W'(i_instr[11:7]);
                        end
                    end
                end
                DECODE: begin
                    if (r_legal) begin
                        r_weRf  <= r_isLoad && (r_rw != '0);
                        r_weMem <= !r_isLoad;
                    end else begin
                        r_illegal <= 1'b1;
                    end
                end
                EXEC: begin
                    r_weRf  <= 1'b0;
                    r_weMem <= 1'b0;
                    r_done  <= 1'b1;
                    if (r_isLoad) begin
                        r_loadCount <= r_loadCount + 1'b1;
                    end else begin
                        r_storeCount <= r_storeCount + 1'b1;
                    end
                end
                default: begin
                    r_weRf  <= 1'b0;
                    r_weMem <= 1'b0;
                end
            endcase
        end
    end

    assign o_instr_ready = (r_state == IDLE);
    assign o_ra          = r_ra;
    assign o_rb          = r_rb;
    assign o_c           = r_c;
    assign o_rw          = r_rw;
    assign o_we_rf       = r_weRf;
    assign o_we_mem      = r_weMem;
    assign o_done        = r_done;
    assign o_illegal     = r_illegal;
    assign o_load_count  = r_loadCount;
    assign o_store_count = r_storeCount;

endmodule

// File: tb/tb_ls_control_unit.sv
// ---------------------------------------------------------------------------
// tb_ls_control_unit
// Directed self-checking bench for ls_control_unit. One instance runs with
// the default 16-bit counters; a second instance with CNT_W=2 exercises
// counter wrap. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ls_control_unit;

    logic        clk;
    logic        rstN;
    logic        instrValid;
    logic [31:0] instr;
    logic        ready;
    logic [4:0]  ra, rb, c, rw;
    logic        weRf, weMem, done, illegal;
    logic [15:0] loadCount, storeCount;

    logic        wValid;
    logic [31:0] wInstr;
    logic        wReady;
    logic [4:0]  wRa, wRb, wC, wRw;
    logic        wWeRf, wWeMem, wDone, wIllegal;
    logic [1:0]  wLoadCount, wStoreCount;

    int checks = 0;
    int errors = 0;

    ls_control_unit #(.CNT_W(16), .OFF_W(5)) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_instr_valid(instrValid), .i_instr(instr),
        .o_instr_ready(ready), .o_ra(ra), .o_rb(rb), .o_c(c), .o_rw(rw),
        .o_we_rf(weRf), .o_we_mem(weMem), .o_done(done), .o_illegal(illegal),
        .o_load_count(loadCount), .o_store_count(storeCount)
    );

    ls_control_unit #(.CNT_W(2), .OFF_W(5)) dutWrap (
        .i_clk(clk), .i_rst_n(rstN), .i_instr_valid(wValid), .i_instr(wInstr),
        .o_instr_ready(wReady), .o_ra(wRa), .o_rb(wRb), .o_c(wC), .o_rw(wRw),
        .o_we_rf(wWeRf), .o_we_mem(wWeMem), .o_done(wDone), .o_illegal(wIllegal),
        .o_load_count(wLoadCount), .o_store_count(wStoreCount)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one word on the main instance, then follows it through
    // DECODE, EXEC (legal only) and the retire/reject cycle.
    task automatic applyStimulus(input logic [31:0] word, input bit legal,
                                 input bit isLoad, input int expRa, input int expRb,
                                 input int expC, input int expRw,
                                 input int expLoads, input int expStores);
        instrValid = 1'b1;
        instr      = word;
        @(negedge clk);
        instrValid = 1'b0;
        checkOutput("dec_ready", ready, 0);
        checkOutput("dec_weRf", weRf, 0);
        checkOutput("dec_weMem", weMem, 0);
        if (legal) begin
            checkOutput("dec_ra", ra, expRa);
            checkOutput("dec_rb", rb, expRb);
            checkOutput("dec_c", c, expC);
            checkOutput("dec_rw", rw, expRw);
            @(negedge clk);
            checkOutput("exe_ready", ready, 0);
            checkOutput("exe_weRf", weRf, (isLoad && expRw != 0) ? 1 : 0);
            checkOutput("exe_weMem", weMem, isLoad ? 0 : 1);
            checkOutput("exe_done", done, 0);
            @(negedge clk);
            checkOutput("ret_done", done, 1);
            checkOutput("ret_weRf", weRf, 0);
            checkOutput("ret_weMem", weMem, 0);
        end else begin
            @(negedge clk);
            checkOutput("ill_pulse", illegal, 1);
            checkOutput("ill_done", done, 0);
            checkOutput("ill_weRf", weRf, 0);
            checkOutput("ill_weMem", weMem, 0);
        end
        checkOutput("end_ready", ready, 1);
        checkOutput("end_loads", loadCount, expLoads);
        checkOutput("end_stores", storeCount, expStores);
        @(negedge clk);
        checkOutput("post_done", done, 0);
        checkOutput("post_illegal", illegal, 0);
    endtask

    // One LD to x0 on the 2-bit-counter instance.
    task automatic runWrap(input int expCount);
        wValid = 1'b1;
        wInstr = 32'h00313003;
        @(negedge clk);
        wValid = 1'b0;
        checkOutput("wrap_dec_weRf", wWeRf, 0);
        @(negedge clk);
        checkOutput("wrap_exe_weRf", wWeRf, 0);
        @(negedge clk);
        checkOutput("wrap_done", wDone, 1);
        checkOutput("wrap_weRf", wWeRf, 0);
        checkOutput("wrap_count", wLoadCount, expCount);
    endtask

    // Main directed sequence.
    initial begin
        rstN       = 1'b0;
        instrValid = 1'b0;
        instr      = 32'd0;
        wValid     = 1'b0;
        wInstr     = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_fields", {ra, rb, c, rw}, 0);
        checkOutput("rst_flags", {weRf, weMem, done, illegal}, 0);
        checkOutput("rst_loads", loadCount, 0);
        checkOutput("rst_stores", storeCount, 0);
        rstN = 1'b1;
        @(negedge clk);

        $display("[TB] LD x5,3(x2)");
        applyStimulus(32'h00313283, 1, 1, 0, 2, 3, 5, 1, 0);
        $display("[TB] SD x7,4(x1)");
        applyStimulus(32'h0070B223, 1, 0, 7, 1, 4, 0, 1, 1);
        $display("[TB] illegal LD offset 32, then ADD");
        applyStimulus(32'h02013283, 0, 1, 0, 0, 0, 0, 1, 1);
        applyStimulus(32'h00000033, 0, 1, 0, 0, 0, 0, 1, 1);

        $display("[TB] back-to-back LD x6,8(x3) / SD x9,12(x4)");
        instrValid = 1'b1;
        instr      = 32'h0081B303;
        @(negedge clk);
        instr = 32'h00923623;
        checkOutput("b2b_dec1_ready", ready, 0);
        checkOutput("b2b_dec1_rw", rw, 6);
        checkOutput("b2b_dec1_rb", rb, 3);
        checkOutput("b2b_dec1_c", c, 8);
        @(negedge clk);
        checkOutput("b2b_exe1_ready", ready, 0);
        checkOutput("b2b_exe1_weRf", weRf, 1);
        @(negedge clk);
        checkOutput("b2b_done1", done, 1);
        checkOutput("b2b_ready1", ready, 1);
        checkOutput("b2b_loads", loadCount, 2);
        @(negedge clk);
        instrValid = 1'b0;
        checkOutput("b2b_dec2_ready", ready, 0);
        checkOutput("b2b_dec2_ra", ra, 9);
        checkOutput("b2b_dec2_rb", rb, 4);
        checkOutput("b2b_dec2_c", c, 12);
        checkOutput("b2b_dec2_rw", rw, 0);
        @(negedge clk);
        checkOutput("b2b_exe2_weMem", weMem, 1);
        checkOutput("b2b_exe2_weRf", weRf, 0);
        @(negedge clk);
        checkOutput("b2b_done2", done, 1);
        checkOutput("b2b_stores", storeCount, 2);
        checkOutput("b2b_loads_keep", loadCount, 2);
        @(negedge clk);
        checkOutput("b2b_no_dup", ready, 1);
        checkOutput("b2b_no_dup_done", done, 0);

        $display("[TB] async reset during SD EXEC");
        instrValid = 1'b1;
        instr      = 32'h0070B223;
        @(negedge clk);
        instrValid = 1'b0;
        @(negedge clk);
        checkOutput("ar_exe_weMem", weMem, 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("ar_weMem_drop", weMem, 0);
        checkOutput("ar_stores", storeCount, 0);
        checkOutput("ar_ready", ready, 1);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("ar_rel_ready", ready, 1);
        checkOutput("ar_rel_stores", storeCount, 0);
        checkOutput("ar_rel_done", done, 0);

        $display("[TB] counter wrap on 2-bit instance");
        runWrap(1);
        runWrap(2);
        runWrap(3);
        runWrap(0);
        runWrap(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
